axi4l_gpio_irq: RTL and testbench
=================================

# axi4l_gpio_irq

Parametrised AXI4-Lite GPIO peripheral with per-pin interrupt detection, intended as the next-generation GPIO slave on the SoC AXI4-Lite interconnect. It provides WIDTH pins with configurable synchroniser depth, atomic set/clear of outputs, and per-pin level/edge interrupts with selectable polarity and write-1-to-clear status. All pins are ORed into one registered interrupt line for the CPU.

## Interface
- WIDTH, 32: number of GPIO pins, 1..32; register bits [31:WIDTH] read 0, writes ignored.
- SYNC_STAGES, 2: flip-flop stages per input synchroniser, >= 2.
- axi.aclk  input  1  sole clock.
- axi.aresetn  input  1  reset; asynchronous assert, active-low.
- axi  axi4l_if.slave  -  remaining AXI4-Lite slave signals (AW, W, B, AR, R channels, 32-bit data, 4-bit strobe).
- gpio_i  input  WIDTH  asynchronous pin inputs.
- gpio_o  output  WIDTH  output data.
- gpio_en  output  WIDTH  output enable, 1 = drive.
- gpio_irq  output  1  registered interrupt request.

## Operation
- Register map, decode on addr[11:2], byte offsets:
  - 0x00 DATA_IN RO: synchronised inputs.
  - 0x04 DATA_OUT RW: drives gpio_o.
  - 0x08 DIR RW: drives gpio_en.
  - 0x0C IRQ_EN RW: per-pin enable.
  - 0x10 IRQ_TYPE RW: 0 level, 1 edge.
  - 0x14 IRQ_POL RW: level 1 = high / 0 = low; edge 1 = rising / 0 = falling.
  - 0x18 IRQ_STATUS RW1C.
  - 0x1C OUT_SET WO: DATA_OUT |= wdata.
  - 0x20 OUT_CLR WO: DATA_OUT &= ~wdata.
- WO registers read 0. wstrb honoured per byte lane on every writable register, including SET/CLR/W1C.
- Unmapped address: bresp/rresp SLVERR, write has no effect, rdata 0. Mapped: OKAY.
- Event detection on synchronised value s and previous value s_d:
  - Level: condition is s == POL.
  - Edge: rising (s & !s_d) or falling (!s & s_d) per POL.
- STATUS[i] sets when IRQ_EN[i] and event. Set and W1C in the same cycle: set wins. Level sources re-set every cycle while active.
- gpio_irq <= |(STATUS & IRQ_EN).
- Reset values: all registers, gpio_o, gpio_en, gpio_irq, synchronisers, s_d = 0. bvalid/rvalid 0; awready/wready/arready 1; bresp/rresp OKAY; rdata 0.

## Timing
- AXI4-Lite, one write and one read in flight. AW and W are accepted independently in any order; the half that arrives first is held in a skid register.
- bvalid asserts the cycle after both AW and W have been accepted. It holds until bready. awready/wready stay low while B is stalled and a captured half is pending.
- Register update is visible on read from the cycle bvalid asserts.
- rvalid asserts the cycle after the AR handshake. rdata/rresp are stable while rvalid && !rready. arready deasserts only while R is stalled.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- gpio_o/gpio_en change the cycle after write acceptance (same edge as bvalid rise).
- Latency from gpio_i change to DATA_IN: SYNC_STAGES cycles. Edge to STATUS: SYNC_STAGES+1 cycles. To gpio_irq: SYNC_STAGES+2 cycles.
- Reset asserted mid-transaction: the transaction is abandoned, with no B/R response after release.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - Adds 0x24 DEBOUNCE RW (16-bit, reset 0).
  - Each pin passes through a stability filter after synchronisation. The filtered value updates only after the synchronised value differs from it for DEBOUNCE+1 consecutive cycles.
  - DATA_IN and interrupt detection use the filtered value. DEBOUNCE = 0 adds exactly one cycle of latency.
- GPIO_DEBOUNCE_EN undefined: no filter; 0x24 is unmapped (SLVERR).

## Test plan
- Reset -> gpio_o = 0, gpio_en = 0, gpio_irq = 0; read 0x18 returns 0 OKAY; bvalid = rvalid = 0.
- Write 0x04 = 0xA5A5_A5A5 with wstrb 0b0011, then write 0x1C = 0x0000_0F00 and 0x20 = 0x0000_0005 -> gpio_o = 0x0000_AFA0.
- W before AW by 3 cycles, bready held low 4 cycles -> single bvalid pulse is held until bready; DIR updates exactly once.
- IRQ_EN[3] = 1, TYPE[3] = 1, POL[3] = 1; gpio_i[3] rises -> STATUS = 0x8 after 3 cycles, gpio_irq after 4. Write 0x18 = 0x8 -> STATUS 0, gpio_irq drops the next cycle.
- Level-low on pin 0 held low; W1C STATUS[0] -> STATUS[0] reads 1 again (set-wins rule).
- Read 0x3FC and write 0x28 -> rresp/bresp SLVERR, rdata 0, no register change; with GPIO_DEBOUNCE_EN, DEBOUNCE = 4 and a 3-cycle glitch on gpio_i[1] -> DATA_IN unchanged, no interrupt.

Source files
------------

// File: rtl/axi4l_gpio_irq_if.sv
// rtl/axi4l_gpio_irq_if.sv - AXI4-Lite bus bundle (clock, reset and the five channels) for the GPIO slave
interface axi4l_if;
  logic        aclk;
  logic        aresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_gpio_irq.sv
// rtl/axi4l_gpio_irq.sv - AXI4-Lite GPIO with per-pin level/edge interrupts
// Optional input debounce filter and DEBOUNCE register enabled by GPIO_DEBOUNCE_EN.
module axi4l_gpio_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  axi4l_if.slave           axi,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_en,
  output logic             gpio_irq
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [9:0] A_DATA_IN    = 10'd0;
  localparam logic [9:0] A_DATA_OUT   = 10'd1;
  localparam logic [9:0] A_DIR        = 10'd2;
  localparam logic [9:0] A_IRQ_EN     = 10'd3;
  localparam logic [9:0] A_IRQ_TYPE   = 10'd4;
  localparam logic [9:0] A_IRQ_POL    = 10'd5;
  localparam logic [9:0] A_IRQ_STATUS = 10'd6;
  localparam logic [9:0] A_OUT_SET    = 10'd7;
  localparam logic [9:0] A_OUT_CLR    = 10'd8;
  localparam logic [9:0] A_DEBOUNCE   = 10'd9;
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [9:0] LAST_IDX = A_DEBOUNCE;
`else
  localparam logic [9:0] LAST_IDX = A_OUT_CLR;
`endif

  logic clk, rst_n;
  assign clk   = axi.aclk;
  assign rst_n = axi.aresetn;

  logic [WIDTH-1:0] data_out_q, dir_q, irq_en_q, irq_type_q, irq_pol_q, irq_status_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] pin_s, pin_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0]      debounce_q;
  logic [WIDTH-1:0] filt_q;
  logic [15:0]      db_cnt_q [WIDTH];

  // Counter tracks consecutive cycles the synchronised pin disagrees with the filtered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
          if (db_cnt_q[i] >= debounce_q) begin
            filt_q[i]   <= sync_q[SYNC_STAGES-1][i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end
  assign pin_s = filt_q;
`else
  assign pin_s = sync_q[SYNC_STAGES-1];
`endif

  logic        aw_held_q, w_held_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [9:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_take, w_take, wr_go, wr_ok;
  logic [9:0]  wr_idx;
  logic [31:0] wr_data, byte_mask;
  logic [3:0]  wr_strb;
  logic [WIDTH-1:0] wr_mask, wr_bits, w1c_bits;
  logic [WIDTH-1:0] edge_ev, level_ev, irq_set;

  assign axi.awready = ~aw_held_q;
  assign axi.wready  = ~w_held_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;

  // A half that arrives alone parks in the skid register until its partner shows up.
  assign aw_take = axi.awvalid & ~aw_held_q;
  assign w_take  = axi.wvalid & ~w_held_q;
  assign wr_go   = (aw_held_q | aw_take) & (w_held_q | w_take) & ~bvalid_q;
  assign wr_idx  = aw_held_q ? aw_idx_q : axi.awaddr[11:2];
  assign wr_data = w_held_q ? w_data_q : axi.wdata;
  assign wr_strb = w_held_q ? w_strb_q : axi.wstrb;
  assign wr_ok   = (wr_idx <= LAST_IDX);

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{wr_strb[b]}};
  end
  assign wr_mask  = byte_mask[WIDTH-1:0];
  assign wr_bits  = wr_data[WIDTH-1:0] & wr_mask;
  assign w1c_bits = (wr_go && wr_idx == A_IRQ_STATUS) ? wr_bits : '0;

  assign edge_ev  = (irq_pol_q & pin_s & ~pin_d_q) | (~irq_pol_q & ~pin_s & pin_d_q);
  assign level_ev = ~(pin_s ^ irq_pol_q);
  assign irq_set  = irq_en_q & ((irq_type_q & edge_ev) | (~irq_type_q & level_ev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_type_q   <= '0;
      irq_pol_q    <= '0;
      irq_status_q <= '0;
      pin_d_q      <= '0;
      gpio_irq     <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
      debounce_q   <= '0;
`endif
    end else begin
      pin_d_q      <= pin_s;
      // A fresh event beats a simultaneous write-1-to-clear.
      irq_status_q <= (irq_status_q & ~w1c_bits) | irq_set;
      gpio_irq     <= |(irq_status_q & irq_en_q);
      if (wr_go) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        case (wr_idx)
          A_DATA_OUT: data_out_q <= (data_out_q & ~wr_mask) | wr_bits;
          A_DIR:      dir_q      <= (dir_q & ~wr_mask) | wr_bits;
          A_IRQ_EN:   irq_en_q   <= (irq_en_q & ~wr_mask) | wr_bits;
          A_IRQ_TYPE: irq_type_q <= (irq_type_q & ~wr_mask) | wr_bits;
          A_IRQ_POL:  irq_pol_q  <= (irq_pol_q & ~wr_mask) | wr_bits;
          A_OUT_SET:  data_out_q <= data_out_q | wr_bits;
          A_OUT_CLR:  data_out_q <= data_out_q & ~wr_bits;
`ifdef GPIO_DEBOUNCE_EN
          A_DEBOUNCE: debounce_q <= (debounce_q & ~byte_mask[15:0]) | (wr_data[15:0] & byte_mask[15:0]);
`endif
          default: ;
        endcase
      end else begin
        if (aw_take) begin
          aw_held_q <= 1'b1;
          aw_idx_q  <= axi.awaddr[11:2];
        end
        if (w_take) begin
          w_held_q <= 1'b1;
          w_data_q <= axi.wdata;
          w_strb_q <= axi.wstrb;
        end
        if (bvalid_q && axi.bready) bvalid_q <= 1'b0;
      end
    end
  end

  assign gpio_o  = data_out_q;
  assign gpio_en = dir_q;

  logic        rvalid_q, ar_take;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q, rd_val;
  logic [9:0]  rd_idx;

  assign rd_idx      = axi.araddr[11:2];
  assign axi.arready = ~(rvalid_q & ~axi.rready);
  assign ar_take     = axi.arvalid & axi.arready;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      A_DATA_IN:    rd_val = 32'(pin_s);
      A_DATA_OUT:   rd_val = 32'(data_out_q);
      A_DIR:        rd_val = 32'(dir_q);
      A_IRQ_EN:     rd_val = 32'(irq_en_q);
      A_IRQ_TYPE:   rd_val = 32'(irq_type_q);
      A_IRQ_POL:    rd_val = 32'(irq_pol_q);
      A_IRQ_STATUS: rd_val = 32'(irq_status_q);
`ifdef GPIO_DEBOUNCE_EN
      A_DEBOUNCE:   rd_val = 32'(debounce_q);
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_take) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= (rd_idx <= LAST_IDX) ? RESP_OKAY : RESP_SLVERR;
    end else if (axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.awaddr[31:12], axi.awaddr[1:0], axi.araddr[31:12], axi.araddr[1:0]};
endmodule

// File: tb/tb_axi4l_gpio_irq.sv
// tb/tb_axi4l_gpio_irq.sv - directed vector bench for axi4l_gpio_irq
module tb_axi4l_gpio_irq;
  localparam int LIMIT = 60;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;
`ifdef GPIO_DEBOUNCE_EN
  localparam int FILT_LAT = 1;
`else
  localparam int FILT_LAT = 0;
`endif
  localparam int IRQ_LAT = 2 + 2 + FILT_LAT;

  axi4l_if axi();
  logic [31:0] gpio_i;
  logic [31:0] gpio_o, gpio_en;
  logic        gpio_irq;

  axi4l_gpio_irq #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .axi(axi), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_en(gpio_en), .gpio_irq(gpio_irq)
  );

  initial begin
    axi.aclk = 1'b0;
    forever #5 axi.aclk = ~axi.aclk;
  end

  int checks = 0;
  int failures = 0;
  int b_hs = 0;

  always @(posedge axi.aclk) if (axi.bvalid && axi.bready) b_hs <= b_hs + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic irq_at_b);
    int  n = 0;
    logic aw_hs, w_hs;
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    while ((axi.awvalid || axi.wvalid) && n < LIMIT) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(negedge axi.aclk); n++;
      if (aw_hs) axi.awvalid = 1'b0;
      if (w_hs)  axi.wvalid = 1'b0;
    end
    while (!axi.bvalid && n < LIMIT) begin @(negedge axi.aclk); n++; end
    resp = axi.bresp;
    irq_at_b = gpio_irq;
    @(negedge axi.aclk);
    axi.bready = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    if (n >= LIMIT) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=0x%08h cycles=%0d limit=%0d", a, n, LIMIT);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    while (!axi.arready && n < LIMIT) begin @(negedge axi.aclk); n++; end
    @(negedge axi.aclk);
    axi.arvalid = 1'b0;
    while (!axi.rvalid && n < LIMIT) begin @(negedge axi.aclk); n++; end
    d = axi.rdata; resp = axi.rresp;
    @(negedge axi.aclk);
    axi.rready = 1'b0;
    if (n >= LIMIT) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=0x%08h cycles=%0d limit=%0d", a, n, LIMIT);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r; logic ib;
    axi_write(a, d, 4'hF, r, ib);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] r;
    axi_read(a, d, r);
    check({name, "_rresp"}, {30'd0, r}, {30'd0, OK});
    check({name, "_rdata"}, d, exp);
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic        ib;
    int          b0;

    vecs.push_back('{1'b0, 32'h18, 32'h0,         4'h0, OK, 32'h0,        "rst_status"});
    vecs.push_back('{1'b1, 32'h04, 32'hA5A5A5A5,  4'h3, OK, 32'h0,        "dout_strb"});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, OK, 32'h0000A5A5, "dout_rb1"});
    vecs.push_back('{1'b1, 32'h1C, 32'h00000F00,  4'hF, OK, 32'h0,        "out_set"});
    vecs.push_back('{1'b1, 32'h20, 32'h00000005,  4'hF, OK, 32'h0,        "out_clr"});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, OK, 32'h0000AFA0, "dout_rb2"});
    vecs.push_back('{1'b1, 32'h1C, 32'hFFFF0000,  4'h4, OK, 32'h0,        "set_lane2"});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, OK, 32'h00FFAFA0, "dout_rb3"});
    vecs.push_back('{1'b1, 32'h20, 32'hFFFFFFFF,  4'h4, OK, 32'h0,        "clr_lane2"});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, OK, 32'h0000AFA0, "dout_rb4"});
    vecs.push_back('{1'b0, 32'h1C, 32'h0,         4'h0, OK, 32'h0,        "set_reads0"});
    vecs.push_back('{1'b0, 32'h20, 32'h0,         4'h0, OK, 32'h0,        "clr_reads0"});
    vecs.push_back('{1'b1, 32'h08, 32'h0000FFFF,  4'hF, OK, 32'h0,        "dir_wr"});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, OK, 32'h0000FFFF, "dir_rb"});
    vecs.push_back('{1'b1, 32'h00, 32'hFFFFFFFF,  4'hF, OK, 32'h0,        "din_wr"});
    vecs.push_back('{1'b0, 32'h00, 32'h0,         4'h0, OK, 32'h0,        "din_rb"});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,        4'h0, SE, 32'h0,        "bad_rd"});
    vecs.push_back('{1'b1, 32'h28, 32'hFFFFFFFF,  4'hF, SE, 32'h0,        "bad_wr"});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, OK, 32'h0000FFFF, "dir_after_bad"});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, OK, 32'h0000AFA0, "dout_after_bad"});
`ifdef GPIO_DEBOUNCE_EN
    vecs.push_back('{1'b1, 32'h24, 32'h00000004,  4'hF, OK, 32'h0,        "deb_wr"});
    vecs.push_back('{1'b0, 32'h24, 32'h0,         4'h0, OK, 32'h00000004, "deb_rb"});
    vecs.push_back('{1'b1, 32'h24, 32'hFFFF0000,  4'hF, OK, 32'h0,        "deb_wr0"});
    vecs.push_back('{1'b0, 32'h24, 32'h0,         4'h0, OK, 32'h0,        "deb_rb0"});
`else
    vecs.push_back('{1'b1, 32'h24, 32'h00000004,  4'hF, SE, 32'h0,        "deb_wr_unmapped"});
    vecs.push_back('{1'b0, 32'h24, 32'h0,         4'h0, SE, 32'h0,        "deb_rd_unmapped"});
`endif

    axi.aresetn = 1'b0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    gpio_i = '0;
    repeat (3) @(negedge axi.aclk);
    axi.aresetn = 1'b1;
    @(negedge axi.aclk);

    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_gpio_en", gpio_en, 32'h0);
    check("rst_gpio_irq", {31'd0, gpio_irq}, 32'h0);
    check("rst_bvalid", {31'd0, axi.bvalid}, 32'h0);
    check("rst_rvalid", {31'd0, axi.rvalid}, 32'h0);
    check("rst_ready", {29'd0, axi.awready, axi.wready, axi.arready}, 32'h7);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, ib);
        check({vecs[i].name, "_bresp"}, {30'd0, r}, {30'd0, vecs[i].resp});
      end else begin
        axi_read(vecs[i].addr, d, r);
        check({vecs[i].name, "_rresp"}, {30'd0, r}, {30'd0, vecs[i].resp});
        check({vecs[i].name, "_rdata"}, d, vecs[i].rdata);
      end
    end
    check("pin_gpio_o", gpio_o, 32'h0000AFA0);
    check("pin_gpio_en", gpio_en, 32'h0000FFFF);

    // W leads AW by three cycles, B stalled for four cycles.
    b0 = b_hs;
    axi.wdata = 32'h000000C3; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    check("early_w_ready", {31'd0, axi.wready}, 32'h1);
    @(negedge axi.aclk);
    axi.wvalid = 1'b0;
    check("early_w_held", {30'd0, axi.wready, axi.bvalid}, 32'h0);
    check("early_w_dir_old", gpio_en, 32'h0000FFFF);
    repeat (2) @(negedge axi.aclk);
    axi.awaddr = 32'h08; axi.awvalid = 1'b1;
    @(negedge axi.aclk);
    axi.awvalid = 1'b0;
    check("late_aw_bvalid", {31'd0, axi.bvalid}, 32'h1);
    check("late_aw_dir", gpio_en, 32'h000000C3);
    for (int k = 0; k < 4; k++) begin
      @(negedge axi.aclk);
      check($sformatf("b_stall_hold%0d", k), {31'd0, axi.bvalid}, 32'h1);
    end
    axi.bready = 1'b1;
    @(negedge axi.aclk);
    axi.bready = 1'b0;
    check("b_released", {31'd0, axi.bvalid}, 32'h0);
    repeat (2) @(negedge axi.aclk);
    check("b_single_pulse", b_hs - b0, 32'd1);
    check("dir_once", gpio_en, 32'h000000C3);

    // Rising-edge interrupt on pin 3 and its exact latency.
    wr(32'h10, 32'h8); wr(32'h14, 32'h8); wr(32'h0C, 32'h8);
    gpio_i[3] = 1'b1;
    for (int k = 1; k <= IRQ_LAT; k++) begin
      @(negedge axi.aclk);
      check($sformatf("edge_irq_cyc%0d", k), {31'd0, gpio_irq}, {31'd0, k >= IRQ_LAT});
    end
    rd_check("edge_status", 32'h18, 32'h8);
    rd_check("edge_din", 32'h00, 32'h8);
    axi_write(32'h18, 32'h8, 4'hF, r, ib);
    check("w1c_irq_at_b", {31'd0, ib}, 32'h1);
    check("w1c_irq_after", {31'd0, gpio_irq}, 32'h0);
    rd_check("w1c_status", 32'h18, 32'h0);

    // Level-low on pin 0 held active: W1C loses to the re-set.
    wr(32'h10, 32'h8); wr(32'h14, 32'h8); wr(32'h0C, 32'h9);
    repeat (3) @(negedge axi.aclk);
    rd_check("lvl_status", 32'h18, 32'h1);
    check("lvl_irq", {31'd0, gpio_irq}, 32'h1);
    wr(32'h18, 32'h1);
    rd_check("lvl_set_wins", 32'h18, 32'h1);
    gpio_i[0] = 1'b1;
    repeat (6) @(negedge axi.aclk);
    wr(32'h18, 32'h1);
    rd_check("lvl_cleared", 32'h18, 32'h0);
    repeat (2) @(negedge axi.aclk);
    check("lvl_irq_off", {31'd0, gpio_irq}, 32'h0);
    rd_check("lvl_din", 32'h00, 32'h9);

`ifdef GPIO_DEBOUNCE_EN
    wr(32'h24, 32'h4);
    wr(32'h10, 32'h2); wr(32'h14, 32'h2); wr(32'h0C, 32'h2);
    gpio_i[1] = 1'b1;
    repeat (3) @(negedge axi.aclk);
    gpio_i[1] = 1'b0;
    repeat (12) @(negedge axi.aclk);
    rd_check("glitch_din", 32'h00, 32'h9);
    check("glitch_irq", {31'd0, gpio_irq}, 32'h0);
    rd_check("glitch_status", 32'h18, 32'h0);
    gpio_i[1] = 1'b1;
    repeat (12) @(negedge axi.aclk);
    rd_check("stable_din", 32'h00, 32'hB);
    check("stable_irq", {31'd0, gpio_irq}, 32'h1);
    rd_check("stable_status", 32'h18, 32'h2);
`endif

    // Reset lands while a B and an R response are both stalled.
    b0 = b_hs;
    axi.awaddr = 32'h04; axi.awvalid = 1'b1;
    axi.wdata = 32'hFFFFFFFF; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    axi.araddr = 32'h08; axi.arvalid = 1'b1; axi.rready = 1'b0;
    @(negedge axi.aclk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    check("mid_bvalid", {31'd0, axi.bvalid}, 32'h1);
    check("mid_rvalid", {31'd0, axi.rvalid}, 32'h1);
    check("mid_gpio_o", gpio_o, 32'hFFFFFFFF);
    axi.aresetn = 1'b0;
    @(negedge axi.aclk);
    check("mid_rst_outs", {gpio_o[15:0], gpio_en[14:0], gpio_irq}, 32'h0);
    axi.aresetn = 1'b1;
    axi.bready = 1'b1; axi.rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge axi.aclk);
      check($sformatf("post_rst_no_resp%0d", k), {30'd0, axi.bvalid, axi.rvalid}, 32'h0);
    end
    axi.bready = 1'b0; axi.rready = 1'b0;
    check("post_rst_b_count", b_hs - b0, 32'd0);
    check("post_rst_ready", {29'd0, axi.awready, axi.wready, axi.arready}, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
